// File: rtl/plab5_mcore_debug_server.sv
// Multicore debug server: accepts 6-bit debug commands, snoops per-core
// retire events, and returns one 32-bit response per command.

// Per-core snoop state: retired-instruction counter and last retired type.
module plab5_mcore_debug_server_core #(
  parameter int p_msg_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   retire_val,
  input  logic [2:0]             retire_type,
  input  logic                   clear,
  output logic [p_msg_nbits-1:0] count,
  output logic [2:0]             last_type
);

  // A clear in the same cycle as a retire wins; the counter wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      last_type <= '0;
    end else if (clear) begin
      count     <= '0;
      last_type <= '0;
    end else if (retire_val) begin
      count     <= count + 1'b1;
      last_type <= retire_type;
    end
  end

endmodule

module plab5_mcore_debug_server #(
  parameter int p_num_cores = 4,
  parameter int p_cmd_nbits = 6,
  parameter int p_msg_nbits = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [p_cmd_nbits-1:0]   req_cmd,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [p_msg_nbits-1:0]   resp_msg,
  input  logic [p_num_cores-1:0]   retire_val,
  input  logic [3*p_num_cores-1:0] retire_type
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_next;

  logic [2:0] op, idx;
  logic       accept, idx_ok;

  logic [p_num_cores-1:0]                  clear;
  logic [p_num_cores-1:0][p_msg_nbits-1:0] count;
  logic [p_num_cores-1:0][2:0]             last_type;

  logic [p_msg_nbits-1:0] sel_count;
  logic [2:0]             sel_type;
  logic [p_msg_nbits-1:0] resp_next;

  assign op      = req_cmd[5:3];
  assign idx     = req_cmd[2:0];
  assign req_rdy = (state == IDLE);
  assign resp_val = (state == RESP);
  assign accept  = req_val && req_rdy;
  assign idx_ok  = (32'(idx) < 32'(p_num_cores));

  // One snoop lane per core; CLEAR only reaches the addressed lane.
  for (genvar i = 0; i < p_num_cores; i++) begin : g_core
    assign clear[i] = accept && (op == 3'd3) && (idx == 3'(i));

    plab5_mcore_debug_server_core #(.p_msg_nbits(p_msg_nbits)) u_core (
      .clk         (clk),
      .reset       (reset),
      .retire_val  (retire_val[i]),
      .retire_type (retire_type[3*i +: 3]),
      .clear       (clear[i]),
      .count       (count[i]),
      .last_type   (last_type[i])
    );
  end

  // Select the addressed core's pre-update state; out-of-range indices read zero.
  always_comb begin
    sel_count = '0;
    sel_type  = '0;
    for (int i = 0; i < p_num_cores; i++) begin
      if (idx == 3'(i)) begin
        sel_count = count[i];
        sel_type  = last_type[i];
      end
    end
  end

  // Response encoding; anything unrecognised or out of range echoes the command.
  always_comb begin
    resp_next = {16'hDEAD, 10'b0, req_cmd};
    if (idx_ok) begin
      case (op)
        3'd0:    resp_next = {16'h0001, 8'(p_num_cores), 5'b0, idx};
        3'd1:    resp_next = {29'b0, sel_type};
        3'd2:    resp_next = sel_count;
        3'd3:    resp_next = '0;
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: accept in IDLE, hold the response until the sink takes it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_val)  state_next = RESP;
      RESP:    if (resp_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response register, loaded only at the accept edge so it holds under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       resp_msg <= '0;
    else if (accept) resp_msg <= resp_next;
  end

endmodule

// File: tb/tb_plab5_mcore_debug_server.sv
// Self-checking bench for plab5_mcore_debug_server: directed scenarios plus
// randomized traffic against a behavioural model of counters and pending response.
module tb_plab5_mcore_debug_server;

  localparam int NC = 4;

  logic        clk, reset;
  logic        req_val, req_rdy, resp_val, resp_rdy;
  logic [5:0]  req_cmd;
  logic [31:0] resp_msg;
  logic [NC-1:0]   retire_val;
  logic [3*NC-1:0] retire_type;

  int errs, checks;

  // Behavioural model: per-core counters/types plus one pending response.
  logic [31:0] m_cnt [NC];
  logic [2:0]  m_lt  [NC];
  bit          m_busy;
  logic [31:0] m_msg;

  plab5_mcore_debug_server #(.p_num_cores(NC), .p_cmd_nbits(6), .p_msg_nbits(32)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_cmd(req_cmd),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .retire_val(retire_val), .retire_type(retire_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_msg(input logic [5:0] cmd);
    int o, c;
    o = int'(cmd[5:3]);
    c = int'(cmd[2:0]);
    if (c >= NC || o > 3) return {16'hDEAD, 10'b0, cmd};
    case (o)
      0: return 32'h0001_0000 + (NC << 8) + c;
      1: return 32'(m_lt[c]);
      2: return m_cnt[c];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_lt[i] = 0; end
    m_busy = 0;
    m_msg  = 0;
  endtask

  // Advance one clock: update the model from the inputs the DUT sees at the edge.
  task automatic cycle();
    bit acc, hs;
    int c;
    acc = req_val && !m_busy;
    hs  = m_busy && resp_rdy;
    c   = int'(req_cmd[2:0]);
    if (acc) m_msg = exp_msg(req_cmd);
    for (int i = 0; i < NC; i++) begin
      if (acc && req_cmd[5:3] == 3'd3 && c == i) begin
        m_cnt[i] = 0; m_lt[i] = 0;
      end else if (retire_val[i]) begin
        m_cnt[i] = m_cnt[i] + 1;
        m_lt[i]  = retire_type[3*i +: 3];
      end
    end
    if (hs)  m_busy = 0;
    if (acc) m_busy = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [5:0] cmd);
    req_val = 1'b1;
    req_cmd = cmd;
    cycle();
    req_val = 1'b0;
    req_cmd = 6'($urandom);
  endtask

  task automatic drain();
    resp_rdy = 1'b1;
    req_val  = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_val = 0; req_cmd = 0; resp_rdy = 1;
    retire_val = 0; retire_type = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (req_rdy !== 1'b1) begin errs++; $display("FAIL reset_req_rdy got=%b exp=1", req_rdy); end
    checks++; if (resp_val !== 1'b0) begin errs++; $display("FAIL reset_resp_val got=%b exp=0", resp_val); end
    checks++; if (resp_msg !== 32'h0) begin errs++; $display("FAIL reset_resp_msg got=%h exp=0", resp_msg); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_proc_id();
    resp_rdy = 1'b1;
    send(6'b000_010);
    checks++; if (resp_val !== 1'b1) begin errs++; $display("FAIL procid_resp_val got=%b exp=1", resp_val); end
    checks++; if (req_rdy !== 1'b0) begin errs++; $display("FAIL procid_req_rdy_low got=%b exp=0", req_rdy); end
    checks++; if (resp_msg !== 32'h0001_0402) begin errs++; $display("FAIL procid_msg got=%h exp=00010402", resp_msg); end
    cycle();
    checks++; if (req_rdy !== 1'b1) begin errs++; $display("FAIL procid_req_rdy_back got=%b exp=1", req_rdy); end
    checks++; if (resp_val !== 1'b0) begin errs++; $display("FAIL procid_resp_done got=%b exp=0", resp_val); end
  endtask

  task automatic test_retire();
    for (int t = 1; t <= 5; t++) begin
      retire_val  = 4'b0010;
      retire_type = 12'(t << 3);
      cycle();
    end
    retire_val = 0;
    send(6'b010_001);
    checks++; if (resp_msg !== 32'd5) begin errs++; $display("FAIL retire_cnt got=%h exp=5", resp_msg); end
    drain();
    send(6'b001_001);
    checks++; if (resp_msg !== 32'd5) begin errs++; $display("FAIL retire_type got=%h exp=5", resp_msg); end
    drain();
  endtask

  task automatic test_backpressure();
    resp_rdy = 1'b0;
    send(6'b000_001);
    req_val = 1'b1;
    req_cmd = 6'b010_001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++; if (resp_val !== 1'b1 || req_rdy !== 1'b0 || resp_msg !== 32'h0001_0401) begin
        errs++; $display("FAIL bp_stall%0d got val=%b rdy=%b msg=%h exp val=1 rdy=0 msg=00010401",
                         k, resp_val, req_rdy, resp_msg);
      end
    end
    resp_rdy = 1'b1;
    cycle();
    checks++; if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      errs++; $display("FAIL bp_handshake got val=%b rdy=%b exp val=0 rdy=1", resp_val, req_rdy);
    end
    cycle();
    req_val = 1'b0;
    checks++; if (resp_val !== 1'b1 || resp_msg !== 32'd5) begin
      errs++; $display("FAIL bp_held_cmd got val=%b msg=%h exp val=1 msg=5", resp_val, resp_msg);
    end
    drain();
  endtask

  task automatic test_clear_same_cycle();
    for (int k = 0; k < 7; k++) begin
      retire_val  = 4'b0001;
      retire_type = 12'($urandom_range(1, 7));
      cycle();
    end
    retire_val = 0;
    send(6'b010_000);
    checks++; if (resp_msg !== 32'd7) begin errs++; $display("FAIL clear_pre_cnt got=%h exp=7", resp_msg); end
    drain();
    retire_val  = 4'b0001;
    retire_type = 12'd6;
    send(6'b011_000);
    retire_val = 0;
    checks++; if (resp_msg !== 32'd0) begin errs++; $display("FAIL clear_resp got=%h exp=0", resp_msg); end
    drain();
    send(6'b010_000);
    checks++; if (resp_msg !== 32'd0) begin errs++; $display("FAIL clear_post_cnt got=%h exp=0", resp_msg); end
    drain();
    send(6'b001_000);
    checks++; if (resp_msg !== 32'd0) begin errs++; $display("FAIL clear_post_type got=%h exp=0", resp_msg); end
    drain();
  endtask

  task automatic test_illegal();
    send(6'b101_000);
    checks++; if (resp_msg !== 32'hDEAD_0028) begin errs++; $display("FAIL illegal_op got=%h exp=dead0028", resp_msg); end
    drain();
    send(6'b000_110);
    checks++; if (resp_msg !== 32'hDEAD_0006) begin errs++; $display("FAIL illegal_core got=%h exp=dead0006", resp_msg); end
    drain();
    send(6'b011_101);
    checks++; if (resp_msg !== 32'hDEAD_001D) begin errs++; $display("FAIL illegal_clear got=%h exp=dead001d", resp_msg); end
    drain();
    for (int c = 0; c < NC; c++) begin
      send(6'(16 + c));
      checks++; if (resp_msg !== m_cnt[c]) begin errs++; $display("FAIL illegal_keep%0d got=%h exp=%h", c, resp_msg, m_cnt[c]); end
      drain();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_val     = 1'($urandom_range(0, 1));
      req_cmd     = 6'($urandom);
      resp_rdy    = ($urandom_range(0, 3) != 0);
      retire_val  = 4'($urandom);
      retire_type = 12'($urandom);
      cycle();
      checks++; if (resp_val !== m_busy || req_rdy !== !m_busy || resp_msg !== m_msg) begin
        errs++; $display("FAIL rand%0d got val=%b rdy=%b msg=%h exp val=%b rdy=%b msg=%h",
                         k, resp_val, req_rdy, resp_msg, m_busy, !m_busy, m_msg);
      end
    end
    retire_val = 0;
    drain();
  endtask

  task automatic test_wrap();
    retire_val = 0;
    force dut.g_core[3].u_core.count = 32'hFFFF_FFFF;
    #1;
    release dut.g_core[3].u_core.count;
    m_cnt[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    send(6'b010_011);
    checks++; if (resp_msg !== 32'hFFFF_FFFF) begin errs++; $display("FAIL wrap_pre got=%h exp=ffffffff", resp_msg); end
    drain();
    retire_val  = 4'b1000;
    retire_type = 12'h300;
    cycle();
    retire_val = 0;
    send(6'b010_011);
    checks++; if (resp_msg !== 32'h0) begin errs++; $display("FAIL wrap_cnt got=%h exp=0", resp_msg); end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      retire_val = 4'b1111;
      cycle();
    end
    retire_val = 0;
    resp_rdy = 1'b0;
    send(6'b000_000);
    checks++; if (resp_val !== 1'b1) begin errs++; $display("FAIL rstmid_pre got=%b exp=1", resp_val); end
    #2 reset = 1'b1;
    #1;
    checks++; if (resp_val !== 1'b0 || req_rdy !== 1'b1 || resp_msg !== 32'h0) begin
      errs++; $display("FAIL rstmid_async got val=%b rdy=%b msg=%h exp val=0 rdy=1 msg=0", resp_val, req_rdy, resp_msg);
    end
    model_reset();
    @(negedge clk);
    reset    = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    checks++; if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      errs++; $display("FAIL rstmid_idle got val=%b rdy=%b exp val=0 rdy=1", resp_val, req_rdy);
    end
    for (int c = 0; c < NC; c++) begin
      send(6'(16 + c));
      checks++; if (resp_msg !== 32'h0) begin errs++; $display("FAIL rstmid_cnt%0d got=%h exp=0", c, resp_msg); end
      drain();
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_proc_id();
    test_retire();
    test_backpressure();
    test_clear_same_cycle();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_debug_server.md
Name: plab5_mcore_debug_server

Overview:
- Downstream responder for the multicore debug command source.
- Accepts 6-bit debug commands over a val/rdy request interface and snoops per-core retire events.
- Keeps per-core retired-instruction counters and last-retired-type registers.
- Returns one 32-bit response message per command over a val/rdy response interface.

Parameters:
- p_num_cores, 4: number of cores snooped; legal range 1..8.
- p_cmd_nbits, 6: command width; fixed layout {op[5:3], core[2:0]}.
- p_msg_nbits, 32: response width; also the retire-counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; asynchronous, active-high.
- req_val  input  1  command valid.
- req_rdy  output  1  block can accept a command.
- req_cmd  input  p_cmd_nbits  command: op = req_cmd[5:3], core index = req_cmd[2:0].
- resp_val  output  1  response valid.
- resp_rdy  input  1  sink accepts the response.
- resp_msg  output  p_msg_nbits  response payload.
- retire_val  input  p_num_cores  bit i: core i retired one instruction this cycle.
- retire_type  input  3*p_num_cores  bits [3i+2:3i]: type of core i's retiring instruction.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high; it applies to every register.
- Reset values:
  - state = IDLE.
  - req_rdy = 1 (combinational from state); resp_val = 0; resp_msg = 0.
  - All count[i] = 0; all last_type[i] = 0.
- FSM states: IDLE, RESP.
  - IDLE: req_rdy = 1, resp_val = 0. When req_val is high, the command is accepted at that edge, the resp_msg register is loaded, and the FSM moves to RESP.
  - RESP: req_rdy = 0, resp_val = 1, resp_msg held stable. When resp_rdy is high, the FSM returns to IDLE. Otherwise it stays in RESP indefinitely.
- Latency and throughput:
  - Command accepted at edge N; resp_val is high from cycle N+1.
  - With resp_rdy tied high, the block processes one command every 2 cycles.
  - No command is ever dropped; the source stalls on req_rdy = 0.
- Response encoding (idx = req_cmd[2:0]; snapshot is taken of register values before any same-edge update):
  - op 0 PROC_ID: {16'h0001, 8'(p_num_cores), 5'b0, idx}.
  - op 1 INST_TYPE: {29'b0, last_type[idx]}.
  - op 2 RETIRE_CNT: count[idx].
  - op 3 CLEAR: response 32'h0; count[idx] and last_type[idx] are cleared at the accept edge.
  - op 4..7, or idx >= p_num_cores: error response {16'hDEAD, 10'b0, req_cmd}. No state changes.
- Snoop logic (runs every cycle, independent of the FSM):
  - When retire_val[i] = 1: count[i] <= count[i] + 1, wrapping modulo 2^32 (0xFFFFFFFF + 1 = 0), and last_type[i] <= retire_type slice i.
  - Multiple cores may retire in the same cycle; each counter updates independently.
- Simultaneous events:
  - CLEAR accepted in the same cycle as a retire on the same core: clear wins; count = 0 and last_type = 0 after the edge.
  - RETIRE_CNT accepted in the same cycle as a retire on the same core: the response returns the pre-increment value; the counter still increments.
- Reset mid-operation: reset in RESP drops resp_val to 0 immediately (asynchronous) and discards the pending response. Counters clear.
- X-safety: req_cmd is ignored unless req_val && req_rdy. retire_type slice i is ignored unless retire_val[i].

Test Plan:
- Reset, then PROC_ID for core 2 (req_cmd = 6'b000_010), resp_rdy = 1 → resp_val high the cycle after accept, resp_msg = 32'h0001_0402. req_rdy is low for exactly 1 cycle.
- Pulse retire_val[1] for 5 cycles with types 1,2,3,4,5, then send RETIRE_CNT core 1 → resp_msg = 5. Then send INST_TYPE core 1 → resp_msg = 5.
- Backpressure: hold resp_rdy = 0 for 4 cycles while in RESP → resp_val and resp_msg stay stable and req_rdy stays 0. Raise resp_rdy → one handshake, then IDLE.
- Send CLEAR core 0 in the same cycle retire_val[0] = 1, with count[0] = 7 beforehand → response 0. A subsequent RETIRE_CNT core 0 returns 0.
- Illegal commands: op 5 core 0 (6'b101_000) → 32'hDEAD_0028. PROC_ID core 6 with p_num_cores = 4 (6'b000_110) → 32'hDEAD_0006. No counter changes.
- Wrap and reset: force count[3] to 0xFFFFFFFF by preload or long run, retire once → RETIRE_CNT core 3 returns 0. Assert reset while in RESP → resp_val = 0 asynchronously; after deassert, state IDLE and all counts 0.
